key_conditioner: RTL and testbench

Parametrised N-channel push-button conditioner between the board pins and the user logic (VGA pattern control and similar). Each channel gets synchronisation, debounce, one-cycle press and release strobes, a long-press strobe and optional auto-repeat. It also drives a debounced LED indicator per key. The block replaces the raw, undebounced key inversion and LED mirroring in the board top level.

---
 rtl/key_conditioner_pkg.sv | 16 +
 rtl/key_conditioner_if.sv | 22 ++
 rtl/key_conditioner_channel.sv | 135 +++++++++++++
 rtl/key_conditioner.sv | 57 +++++
 tb/tb_key_conditioner.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the key conditioner: per-channel FSM encoding and
// the counter width helper.
package key_pkg;

    typedef enum logic [1:0] {
        ST_REL  = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } key_state_e;

    // Bits needed to count 0 .. n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key pins and conditioned key outputs for the key conditioner.
interface key_conditioner_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_raw_i;
    logic [N_KEYS-1:0] key_level_o;
    logic [N_KEYS-1:0] press_o;
    logic [N_KEYS-1:0] release_o;
    logic [N_KEYS-1:0] long_press_o;
    logic [N_KEYS-1:0] repeat_o;
    logic [N_KEYS-1:0] led_o;

    modport master (
        output key_raw_i,
        input  key_level_o, press_o, release_o, long_press_o, repeat_o, led_o
    );

    modport slave (
        input  key_raw_i,
        output key_level_o, press_o, release_o, long_press_o, repeat_o, led_o
    );
endinterface

// File: rtl/key_conditioner_channel.sv
// One key channel: synchroniser, debounce, hold FSM with long-press/repeat.
// state   | meaning
// ST_REL  | key released, waiting for an accepted press
// ST_HELD | key held, hold counter running towards the long-press point
// ST_LONG | long press reached, repeat counter running while held
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 10_000_000,
    parameter int REPEAT_EN    = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic repeat_o
);
    localparam int DW = cnt_width(DEBOUNCE_CYC);
    localparam int HW = cnt_width(LONG_CYC);
    localparam int RW = cnt_width(REPEAT_CYC);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    key_state_e    state_q, state_d;
    logic          press_q, press_d, release_q, release_d;
    logic          long_q, long_d, repeat_q, repeat_d;
    logic          accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b00;
            level_q   <= 1'b0;
            deb_q     <= '0;
            hold_q    <= '0;
            rep_q     <= '0;
            state_q   <= ST_REL;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            level_q   <= level_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    always_comb begin
        level_d   = level_q;
        deb_d     = deb_q;
        accept    = 1'b0;
        state_d   = state_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        if (sync_q[1] == level_q) begin
            deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
            accept  = 1'b1;
            level_d = ~level_q;
            deb_d   = '0;
        end else begin
            deb_d = deb_q + DW'(1);
        end

        // level and FSM move in lockstep, so an accept in REL is always a press
        case (state_q)
            ST_REL: begin
                if (accept) begin
                    state_d = ST_HELD;
                    press_d = 1'b1;
                    hold_d  = '0;
                end
            end
            ST_HELD: begin
                if (accept) begin
                    state_d   = ST_REL;
                    release_d = 1'b1;
                    hold_d    = '0;
                    rep_d     = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                    rep_d   = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_LONG: begin
                if (accept) begin
                    state_d   = ST_REL;
                    release_d = 1'b1;
                    hold_d    = '0;
                    rep_d     = '0;
                end else if (REPEAT_EN != 0) begin
                    if (rep_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        rep_d    = '0;
                    end else begin
                        rep_d = rep_q + RW'(1);
                    end
                end
            end
            default: state_d = ST_REL;
        endcase
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;
    assign repeat_o     = repeat_q;
endmodule

// File: rtl/key_conditioner.sv
// N-channel push-button conditioner: input polarity normalisation, per-key
// channels and a registered LED indicator of the debounced level.
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_KEYS         = 4,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int LED_ACTIVE_LOW = 1,
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int LONG_CYC       = 50_000_000,
    parameter int REPEAT_CYC     = 10_000_000,
    parameter int REPEAT_EN      = 1
) (
    input logic               clk,
    input logic               reset,
    key_conditioner_if.slave  kif
);
    localparam logic [N_KEYS-1:0] LED_OFF = (LED_ACTIVE_LOW != 0) ? '1 : '0;

    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] level_v, press_v, release_v, long_v, repeat_v;
    logic [N_KEYS-1:0] led_q, led_d;

    assign key_n = (KEY_ACTIVE_LOW != 0) ? ~kif.key_raw_i : kif.key_raw_i;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .REPEAT_EN    (REPEAT_EN)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .key_i        (key_n[g]),
            .level_o      (level_v[g]),
            .press_o      (press_v[g]),
            .release_o    (release_v[g]),
            .long_press_o (long_v[g]),
            .repeat_o     (repeat_v[g])
        );
    end

    assign led_d = (LED_ACTIVE_LOW != 0) ? ~level_v : level_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) led_q <= LED_OFF;
        else       led_q <= led_d;
    end

    assign kif.key_level_o  = level_v;
    assign kif.press_o      = press_v;
    assign kif.release_o    = release_v;
    assign kif.long_press_o = long_v;
    assign kif.repeat_o     = repeat_v;
    assign kif.led_o        = led_q;
endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: one instance with auto-repeat, one without.
module tb_key_conditioner;
    localparam int NK   = 4;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    typedef struct packed {
        logic [NK-1:0] level;
        logic [NK-1:0] led;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] lng;
        logic [NK-1:0] rep;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] key_raw = '1;

    always #5 clk = ~clk;

    key_conditioner_if #(.N_KEYS(NK)) if_a ();
    key_conditioner_if #(.N_KEYS(NK)) if_b ();
    assign if_a.key_raw_i = key_raw;
    assign if_b.key_raw_i = key_raw;

    key_conditioner #(
        .N_KEYS(NK), .KEY_ACTIVE_LOW(1), .LED_ACTIVE_LOW(1),
        .DEBOUNCE_CYC(DEB), .LONG_CYC(LONG), .REPEAT_CYC(REP), .REPEAT_EN(1)
    ) dut_a (.clk(clk), .reset(reset), .kif(if_a.slave));

    key_conditioner #(
        .N_KEYS(NK), .KEY_ACTIVE_LOW(1), .LED_ACTIVE_LOW(1),
        .DEBOUNCE_CYC(DEB), .LONG_CYC(LONG), .REPEAT_CYC(REP), .REPEAT_EN(0)
    ) dut_b (.clk(clk), .reset(reset), .kif(if_b.slave));

    rec_t q_a[$];
    rec_t q_b[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // reference model state: raw sample history per key, accepted level, press time
    logic [15:0] hist[NK];
    logic        lvl[NK];
    int          pt[NK];

    // observed-strobe bookkeeping for the directed checks
    int press_cnt[NK] = '{default: 0};
    int press_cyc[NK] = '{default: -1};
    int long_a_cnt[NK] = '{default: 0};
    int long_b_cnt[NK] = '{default: 0};
    int rep_a_cnt[NK] = '{default: 0};
    int rep_b_cnt = 0;

    // Model: a key's level flips once the synchronised samples (raw delayed by two
    // edges) have disagreed with it for DEB consecutive edges; long/repeat times
    // follow from the distance to the press edge.
    always @(posedge clk) begin : model
        rec_t ra, rb;
        logic all_diff;
        int   d;
        cyc = cyc + 1;
        ra = '0;
        if (reset) begin
            for (int k = 0; k < NK; k++) begin
                hist[k] = '0;
                lvl[k]  = 1'b0;
                pt[k]   = -1;
            end
            ra.led = '1;
        end else begin
            for (int k = 0; k < NK; k++) begin
                ra.led[k] = ~lvl[k];
                hist[k] = {hist[k][14:0], ~key_raw[k]};
                all_diff = 1'b1;
                for (int j = 2; j <= DEB + 1; j++)
                    if (hist[k][j] == lvl[k]) all_diff = 1'b0;
                if (all_diff) begin
                    lvl[k] = ~lvl[k];
                    if (lvl[k]) begin
                        ra.press[k] = 1'b1;
                        pt[k] = cyc;
                    end else begin
                        ra.rel[k] = 1'b1;
                        pt[k] = -1;
                    end
                end else if (lvl[k]) begin
                    d = cyc - pt[k];
                    if (d == LONG) ra.lng[k] = 1'b1;
                    if (d > LONG && ((d - LONG) % REP) == 0) ra.rep[k] = 1'b1;
                end
                ra.level[k] = lvl[k];
            end
        end
        rb = ra;
        rb.rep = '0;
        q_a.push_back(ra);
        q_b.push_back(rb);
    end

    task automatic cmp(input string nm, input logic [NK-1:0] got, input logic [NK-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    initial begin : monitor
        rec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() == 0 || q_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_empty cyc=%0d got=empty want=record", cyc);
            end else begin
                e = q_a.pop_front();
                cmp("a_level", if_a.key_level_o, e.level);
                cmp("a_led", if_a.led_o, e.led);
                cmp("a_press", if_a.press_o, e.press);
                cmp("a_release", if_a.release_o, e.rel);
                cmp("a_long", if_a.long_press_o, e.lng);
                cmp("a_repeat", if_a.repeat_o, e.rep);
                e = q_b.pop_front();
                cmp("b_level", if_b.key_level_o, e.level);
                cmp("b_led", if_b.led_o, e.led);
                cmp("b_press", if_b.press_o, e.press);
                cmp("b_release", if_b.release_o, e.rel);
                cmp("b_long", if_b.long_press_o, e.lng);
                cmp("b_repeat", if_b.repeat_o, e.rep);
            end
            for (int k = 0; k < NK; k++) begin
                if (if_a.press_o[k] === 1'b1) begin
                    press_cnt[k]++;
                    press_cyc[k] = cyc;
                end
                if (if_a.long_press_o[k] === 1'b1) long_a_cnt[k]++;
                if (if_b.long_press_o[k] === 1'b1) long_b_cnt[k]++;
                if (if_a.repeat_o[k] === 1'b1) rep_a_cnt[k]++;
                if (if_b.repeat_o[k] === 1'b1) rep_b_cnt++;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        int t0, lp0, lp3, rp, lb;
        int k;
        wait_cyc(3);
        cmp("reset_led", if_a.led_o, 4'b1111);
        cmp("reset_level", if_a.key_level_o, 4'b0000);
        reset = 1'b0;
        wait_cyc(30);
        check_int("quiet_press_count", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

        // clean press on key 0
        key_raw[0] = 1'b0;
        t0 = cyc;
        wait_cyc(12);
        check_int("press0_latency", press_cyc[0] - t0, 6);
        check_int("press0_count", press_cnt[0], 1);
        key_raw[0] = 1'b1;
        wait_cyc(15);

        // bounce on key 1
        key_raw[1] = 1'b0; wait_cyc(3);
        key_raw[1] = 1'b1; wait_cyc(2);
        key_raw[1] = 1'b0; wait_cyc(3);
        key_raw[1] = 1'b1; wait_cyc(15);
        check_int("bounce_press1", press_cnt[1], 0);

        // long press with repeat on key 2: release lands 60 cycles after press
        rp = rep_a_cnt[2];
        lb = long_b_cnt[2];
        key_raw[2] = 1'b0; wait_cyc(60);
        key_raw[2] = 1'b1; wait_cyc(20);
        check_int("repeat_count_a", rep_a_cnt[2] - rp, 4);
        check_int("long_count_b", long_b_cnt[2] - lb, 1);
        check_int("repeat_count_b", rep_b_cnt, 0);

        // simultaneous keys 0 and 3, then reset at hold cycle 10
        lp0 = long_a_cnt[0];
        lp3 = long_a_cnt[3];
        key_raw[0] = 1'b0;
        key_raw[3] = 1'b0;
        t0 = cyc;
        wait_cyc(8);
        check_int("simul_press0", press_cyc[0] - t0, 6);
        check_int("simul_press3", press_cyc[3] - t0, 6);
        wait_cyc(8);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        t0 = cyc;
        wait_cyc(10);
        check_int("post_reset_press0", press_cyc[0] - t0, 6);
        check_int("aborted_long0", long_a_cnt[0] - lp0, 0);
        check_int("aborted_long3", long_a_cnt[3] - lp3, 0);
        key_raw = '1;
        wait_cyc(20);

        // randomised toggling with occasional reset pulses
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, NK - 1);
            key_raw[k] = ~key_raw[k];
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                wait_cyc(1);
                reset = 1'b0;
            end
            wait_cyc($urandom_range(1, 40));
        end
        key_raw = '1;
        wait_cyc(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
